match_window_counter: RTL and testbench



---
 rtl/match_window_counter_if.sv | 25 ++
 rtl/match_window_counter.sv | 117 +++++++++++
 tb/tb_match_window_counter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/match_window_counter_if.sv
// Signal bundle between a match source, the window counter and its result consumer.
// The counter takes the slave modport; the stimulus/consumer side takes master.
interface match_window_counter_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
);
  logic             z;
  logic             enable;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] cnt_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic             lost;

  modport master (
    output z, enable, win_len, out_ready,
    input  cnt_out, out_valid, ovf, lost
  );

  modport slave (
    input  z, enable, win_len, out_ready,
    output cnt_out, out_valid, ovf, lost
  );
endinterface

// File: rtl/match_window_counter.sv
// Counts match pulses over a programmable cycle window and offers each window's
// count on a valid/ready port, with saturation and lost-pulse flags.
module match_window_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  match_window_counter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCount, StHold} state_e;

  state_e             r_state, w_state_d;
  logic [WIN_W-1:0]   r_len, w_len_d;
  logic [WIN_W-1:0]   r_cyc, w_cyc_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_wovf, w_wovf_d;
  logic [CNT_W-1:0]   r_cnt_out, w_cnt_out_d;
  logic               r_ovf, w_ovf_d;
  logic               r_valid, w_valid_d;
  logic               r_lost, w_lost_d;

  logic [WIN_W-1:0]   w_len_eff;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_sat;
  logic               w_last;
  logic               w_hs;

  // A zero window length is treated as a single-cycle window.
  assign w_len_eff = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
  assign w_sat     = bus.z && (&r_cnt);
  assign w_cnt_inc = (bus.z && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_last    = (r_cyc == r_len - WIN_W'(1));
  assign w_hs      = r_valid && bus.out_ready;

  always_comb begin
    w_state_d   = r_state;
    w_len_d     = r_len;
    w_cyc_d     = r_cyc;
    w_cnt_d     = r_cnt;
    w_wovf_d    = r_wovf;
    w_cnt_out_d = r_cnt_out;
    w_ovf_d     = r_ovf;
    w_valid_d   = r_valid;
    w_lost_d    = r_lost | (bus.z && (r_state != StCount));

    case (r_state)
      StIdle: begin
        if (bus.enable) begin
          w_len_d   = w_len_eff;
          w_cyc_d   = '0;
          w_cnt_d   = '0;
          w_wovf_d  = 1'b0;
          w_state_d = StCount;
        end
      end
      StCount: begin
        w_cnt_d  = w_cnt_inc;
        w_wovf_d = r_wovf | w_sat;
        w_cyc_d  = r_cyc + WIN_W'(1);
        if (w_last) begin
          w_cnt_out_d = w_cnt_inc;
          w_ovf_d     = r_wovf | w_sat;
          w_valid_d   = 1'b1;
          w_state_d   = StHold;
        end
      end
      StHold: begin
        if (w_hs) begin
          w_valid_d = 1'b0;
          if (bus.enable) begin
            // Back-to-back window: restart with no idle gap.
            w_len_d   = w_len_eff;
            w_cyc_d   = '0;
            w_cnt_d   = '0;
            w_wovf_d  = 1'b0;
            w_state_d = StCount;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_len     <= WIN_W'(1);
      r_cyc     <= '0;
      r_cnt     <= '0;
      r_wovf    <= 1'b0;
      r_cnt_out <= '0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_len     <= w_len_d;
      r_cyc     <= w_cyc_d;
      r_cnt     <= w_cnt_d;
      r_wovf    <= w_wovf_d;
      r_cnt_out <= w_cnt_out_d;
      r_ovf     <= w_ovf_d;
      r_valid   <= w_valid_d;
      r_lost    <= w_lost_d;
    end
  end

  assign bus.cnt_out   = r_cnt_out;
  assign bus.out_valid = r_valid;
  assign bus.ovf       = r_ovf;
  assign bus.lost      = r_lost;

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter: default-width instance plus a 2-bit
// counter instance for saturation.
module tb_match_window_counter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  match_window_counter_if #(.CNT_W(8), .WIN_W(16)) bus ();
  match_window_counter_if #(.CNT_W(2), .WIN_W(16)) sbus ();

  match_window_counter #(.CNT_W(8), .WIN_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  match_window_counter #(.CNT_W(2), .WIN_W(16)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply z = zpat[i] on window cycle i+1 for n cycles (main instance).
  task automatic drive_z(input int n, input logic [31:0] zpat);
    for (int i = 0; i < n; i++) begin
      bus.z = zpat[i];
      step();
    end
    bus.z = 1'b0;
  endtask

  task automatic drive_sz(input int n, input logic [31:0] zpat);
    for (int i = 0; i < n; i++) begin
      sbus.z = zpat[i];
      step();
    end
    sbus.z = 1'b0;
  endtask

  logic [13:0] xpat;
  logic [2:0]  hist;
  logic        xbit;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.z = 1'b0;  bus.enable = 1'b0;  bus.win_len = '0;  bus.out_ready = 1'b0;
    sbus.z = 1'b0; sbus.enable = 1'b0; sbus.win_len = '0; sbus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset in the middle of a window discards it
    bus.enable = 1'b1; bus.win_len = 16'd10; bus.out_ready = 1'b1;
    step();
    bus.enable = 1'b0;
    drive_z(3, 32'b111);
    rst = 1'b1;
    bus.z = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus.z = 1'b0;
    check_eq("rst_cnt_out", 32'(bus.cnt_out), 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
    check_eq("rst_lost", 32'(bus.lost), 32'd0);

    // Basic window: len 10, z on cycles 2, 5, 8
    bus.enable = 1'b1; bus.win_len = 16'd10; bus.out_ready = 1'b1;
    step();
    drive_z(9, 32'b0_1001_0010);
    check_eq("basic_valid_early", 32'(bus.out_valid), 32'd0);
    drive_z(1, 32'b0);
    check_eq("basic_valid", 32'(bus.out_valid), 32'd1);
    check_eq("basic_cnt", 32'(bus.cnt_out), 32'd3);
    check_eq("basic_ovf", 32'(bus.ovf), 32'd0);
    check_eq("basic_lost", 32'(bus.lost), 32'd0);

    // Handshake with enable high starts the next window at once
    bus.win_len = 16'd3;
    step();
    check_eq("b2b_valid_fall", 32'(bus.out_valid), 32'd0);
    check_eq("b2b_cnt_retained", 32'(bus.cnt_out), 32'd3);
    drive_z(3, 32'b101);
    check_eq("b2b_valid", 32'(bus.out_valid), 32'd1);
    check_eq("b2b_cnt", 32'(bus.cnt_out), 32'd2);

    // Backpressure: held result stays stable, z pulses in HOLD are lost
    bus.out_ready = 1'b0; bus.enable = 1'b0;
    drive_z(6, 32'b00_1010);
    check_eq("bp_valid_held", 32'(bus.out_valid), 32'd1);
    check_eq("bp_cnt_held", 32'(bus.cnt_out), 32'd2);
    check_eq("bp_lost", 32'(bus.lost), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check_eq("bp_valid_fall", 32'(bus.out_valid), 32'd0);
    check_eq("bp_cnt_retained", 32'(bus.cnt_out), 32'd2);

    // win_len = 0 acts as a one-cycle window
    bus.out_ready = 1'b0; bus.enable = 1'b1; bus.win_len = 16'd0;
    step();
    bus.enable = 1'b0;
    drive_z(1, 32'b1);
    check_eq("len0_valid", 32'(bus.out_valid), 32'd1);
    check_eq("len0_cnt", 32'(bus.cnt_out), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check_eq("len0_valid_fall", 32'(bus.out_valid), 32'd0);

    // enable dropped mid-window: window completes, then back to IDLE
    bus.enable = 1'b1; bus.win_len = 16'd4;
    step();
    bus.enable = 1'b0;
    drive_z(4, 32'b1001);
    check_eq("endrop_valid", 32'(bus.out_valid), 32'd1);
    check_eq("endrop_cnt", 32'(bus.cnt_out), 32'd2);
    step();
    for (int i = 0; i < 6; i++) step();
    check_eq("endrop_idle", 32'(bus.out_valid), 32'd0);

    // Detector-driven: overlapping 1001 Mealy detector feeding z
    xpat = 14'b01_0010_0100_1001;  // bit i = x at window cycle i+1
    hist = 3'b000;
    bus.out_ready = 1'b0; bus.enable = 1'b1; bus.win_len = 16'd14;
    step();
    bus.enable = 1'b0;
    for (int i = 0; i < 14; i++) begin
      xbit  = xpat[i];
      bus.z = xbit && (hist == 3'b100);
      hist  = {hist[1:0], xbit};
      step();
    end
    bus.z = 1'b0;
    check_eq("det_valid", 32'(bus.out_valid), 32'd1);
    check_eq("det_cnt", 32'(bus.cnt_out), 32'd4);
    check_eq("det_ovf", 32'(bus.ovf), 32'd0);
    bus.out_ready = 1'b1;
    step();
    check_eq("det_valid_fall", 32'(bus.out_valid), 32'd0);
    check_eq("lost_sticky", 32'(bus.lost), 32'd1);

    // Saturation with a 2-bit counter
    sbus.enable = 1'b1; sbus.win_len = 16'd8; sbus.out_ready = 1'b0;
    step();
    drive_sz(8, 32'b0001_1111);
    check_eq("sat_valid", 32'(sbus.out_valid), 32'd1);
    check_eq("sat_cnt", 32'(sbus.cnt_out), 32'd3);
    check_eq("sat_ovf", 32'(sbus.ovf), 32'd1);
    step();
    check_eq("sat_ovf_held", 32'(sbus.ovf), 32'd1);
    sbus.out_ready = 1'b1;
    step();
    check_eq("sat_valid_fall", 32'(sbus.out_valid), 32'd0);
    sbus.enable = 1'b0;
    drive_sz(8, 32'b0000_0100);
    check_eq("sat2_cnt", 32'(sbus.cnt_out), 32'd1);
    check_eq("sat2_ovf", 32'(sbus.ovf), 32'd0);
    check_eq("sat_lost", 32'(sbus.lost), 32'd0);
    step();
    check_eq("sat2_valid_fall", 32'(sbus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
